// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin shared unsigned 8x8->16 multiplier with a LAT-stage tagged pipeline.
// Optional per-requester saturating accept counters when MUL_SHARE_ARB_STATS_EN is defined.
`default_nettype none

module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [15:0]         rsp_product
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [16*NREQ-1:0]  stat_cnt
`endif
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           any_valid;
  logic           adv;
  logic           accept;
  logic [7:0]     a_sel;
  logic [7:0]     b_sel;

  assign adv       = !rsp_valid | rsp_ready;
  assign any_valid = |req_valid;
  assign accept    = rst_n & adv & any_valid;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign a_sel     = req_a[8*grant +: 8];
  assign b_sel     = req_b[8*grant +: 8];

  // Scan from the far end so the last hit is the nearest index at or after rr_ptr.
  always_comb begin
    grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) grant = IDW'((int'(rr_ptr) + k) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  logic           in_valid;
  logic [IDW-1:0] in_id;
  logic [7:0]     in_a;
  logic [7:0]     in_b;
  logic [15:0]    in_prod;

  generate
    if (LAT == 1) begin : g_direct
      assign in_valid = accept;
      assign in_id    = grant;
      assign in_a     = a_sel;
      assign in_b     = b_sel;
    end else begin : g_pipe
      logic [LAT-2:0] v_q;
      logic [IDW-1:0] id_q [LAT-1];
      logic [7:0]     a_q  [LAT-1];
      logic [7:0]     b_q  [LAT-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= '0;
        end else if (adv) begin
          v_q[0] <= accept;
          for (int i = 1; i < LAT - 1; i++) v_q[i] <= v_q[i-1];
        end
      end

      // Operand fields need no reset; they are qualified by v_q.
      always_ff @(posedge clk) begin
        if (adv) begin
          id_q[0] <= grant;
          a_q[0]  <= a_sel;
          b_q[0]  <= b_sel;
          for (int i = 1; i < LAT - 1; i++) begin
            id_q[i] <= id_q[i-1];
            a_q[i]  <= a_q[i-1];
            b_q[i]  <= b_q[i-1];
          end
        end
      end

      assign in_valid = v_q[LAT-2];
      assign in_id    = id_q[LAT-2];
      assign in_a     = a_q[LAT-2];
      assign in_b     = b_q[LAT-2];
    end
  endgenerate

  assign in_prod = 16'(in_a) * 16'(in_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else if (adv) begin
      rsp_valid <= in_valid;
      if (in_valid) begin
        rsp_id      <= in_id;
        rsp_product <= in_prod;
      end
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
      always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
          stat_cnt[16*i +: 16] <= '0;
        end else if (accept && grant == IDW'(i) && stat_cnt[16*i +: 16] != 16'hFFFF) begin
          stat_cnt[16*i +: 16] <= stat_cnt[16*i +: 16] + 16'd1;
        end
      end
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed stimulus with a queue scoreboard and a negedge monitor.
`default_nettype none

module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_product;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic              stat_clr;
  logic [16*NREQ-1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  mul_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_cnt    (stat_cnt)
`endif
  );

  // Per-requester operands with hand-computed products.
  logic [7:0]  op_a [NREQ];
  logic [7:0]  op_b [NREQ];
  logic [15:0] op_p [NREQ];
  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    p;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_rr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    op_a[i] = a;
    op_b[i] = b;
    op_p[i] = p;
  endtask

  // Monitor: evaluates what the coming rising edge will do.
  logic           have_prev = 1'b0;
  logic [IDW-1:0] prev_id;
  logic [15:0]    prev_p;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr      = 0;
      have_prev = 1'b0;
      q.delete();
    end else begin
      int  g;
      bit  found;
      bit  adv;
      logic [NREQ-1:0] exp_ready;
      exp_t e;
      adv   = !rsp_valid || rsp_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      exp_ready = (adv && found) ? (NREQ'(1) << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (have_prev) begin
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_id", 32'(rsp_id), 32'(prev_id));
        check("stall_product", 32'(rsp_product), 32'(prev_p));
      end
      have_prev = rsp_valid && !rsp_ready;
      prev_id   = rsp_id;
      prev_p    = rsp_product;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_id), 32'hDEAD);
        end else begin
          e = q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_product", 32'(rsp_product), 32'(e.p));
        end
      end
      if (adv && found) begin
        q.push_back('{id: IDW'(g), p: op_p[g]});
        grant_log.push_back(g);
        m_rr = (g + 1) % NREQ;
      end
    end
  end

  task automatic drain_check(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    set_op(0, 8'd3,   8'd5, 16'd15);
    set_op(1, 8'd200, 8'd2, 16'd400);
    set_op(2, 8'h10,  8'h10, 16'h0100);
    set_op(3, 8'd7,   8'd9, 16'd63);
`ifdef MUL_SHARE_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset with every requester asking.
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_product", 32'(rsp_product), 32'd0);

    // All four continuously valid: six accepts, round-robin from 0.
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 req_valid = 4'h0;
    drain_check("drain_rr");
    check("grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check("grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
    end

    // Single requester latency: response visible one edge after accept.
    @(posedge clk);
    #1;
    set_op(1, 8'hFF, 8'hFF, 16'hFE01);
    req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = 4'h0;
    check("lat_not_early", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(rsp_valid), 32'd1);
    check("lat_id", 32'(rsp_id), 32'd1);
    check("lat_product", 32'(rsp_product), 32'hFE01);
    drain_check("drain_single");

    // Backpressure with a full pipeline.
    set_op(0, 8'd1,   8'd1,   16'd1);
    set_op(1, 8'd12,  8'd12,  16'd144);
    set_op(2, 8'd255, 8'd1,   16'd255);
    set_op(3, 8'd0,   8'd77,  16'd0);
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = 4'h0;
    drain_check("drain_bp");

    // Mid-operation reset with two ops in flight from requester 2.
    set_op(2, 8'd9, 8'd9, 16'd81);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'h0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'hF;
    #1 check("midrst_rr_zero", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1 req_valid = 4'h0;
    drain_check("drain_midrst");

`ifdef MUL_SHARE_ARB_STATS_EN
    // Saturation on requester 2, then clear racing an accept.
    set_op(2, 8'd2, 8'd3, 16'd6);
    req_valid = 4'b0100;
    repeat (70000) @(posedge clk);
    #1 check("stat_saturate", 32'(stat_cnt[47:32]), 32'hFFFF);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr  = 1'b0;
    req_valid = 4'h0;
    check("stat_clr", 32'(stat_cnt[47:32]), 32'd0);
    drain_check("drain_stats");
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one unsigned 8x8->16 multiplier datapath among NREQ requesters.
- Arbitration is round-robin across the requesters.
- Operands pass through a LAT-stage pipeline and return on a single tagged response bus with valid/ready backpressure.
- Sits between client engines (filters, MAC sequencers) and the arithmetic library multiplier. Throughput is one product per cycle when unstalled.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 2, pipeline depth from accept to response valid (1..4)
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_a  input  8*NREQ  operand A, requester i at bits [8i+7:8i]
- req_b  input  8*NREQ  operand B, same packing
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  IDW  index of requester owning rsp_product
- rsp_product  output  16  unsigned product a*b

Behaviour:
Interface and reset:
- One clock domain: clk.
- Reset is synchronous, active-low, on rst_n, sampled on the rising edge of clk.
- While rst_n=0:
  - req_ready=0.
  - All pipeline valid bits clear.
  - rsp_valid=0, rsp_id=0, rsp_product=0.
  - Round-robin pointer rr_ptr=0.
- Reset mid-operation discards every in-flight product. Nothing is replayed.

Pipeline and stall:
- adv = !rsp_valid | rsp_ready.
- When adv=0, the whole pipeline holds: all stages, rsp_valid, rsp_id and rsp_product stay stable.
- Bubbles are not compressed during a stall.

Arbitration (combinational):
- Grant g = first index i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
- req_ready[g] = adv & any(req_valid). All other req_ready bits are 0.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.

Accept:
- Accept occurs when req_valid[g] & req_ready[g].
- On accept, stage 0 captures {id=g, a, b} with valid=1, and rr_ptr <= (g+1) mod NREQ.
- With no accept while adv=1, stage 0 loads valid=0 and rr_ptr is held.

Latency and ordering:
- An operand accepted at edge t appears with rsp_valid=1 after edge t+LAT-1, provided there are no stalls. With LAT=1, it is visible right after the accepting edge.
- Each stall cycle adds exactly one cycle.
- Responses leave in accept order.

Arithmetic:
- Unsigned full-width product, no truncation. 0xFF*0xFF = 0xFE01.
- The multiply may be computed in any stage, but the result is registered at the output stage.
- rsp_id and rsp_product hold their last values when rsp_valid=0.

Fairness:
- A requester holding req_valid=1 is granted within NREQ accept cycles.
- A requester may drop req_valid before being accepted. No state is kept for it.

Simultaneous events:
- Output drain and a new accept in the same cycle (rsp_ready=1, rsp_valid=1) are legal. Both occur.

Optional Feature:
- Macro: MUL_SHARE_ARB_STATS_EN.
- When defined, add the following ports:
  - input stat_clr (1 bit)
  - output stat_cnt (16*NREQ bits), one saturating 16-bit accept counter per requester.
- Counter i increments on each accept by requester i and saturates at 0xFFFF.
- stat_clr=1 zeroes all counters. It has priority over an increment in the same cycle.
- Counters reset to 0 on rst_n=0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with LAT=2: assert rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0. The first accept after release goes to requester 0.
- Single requester: req1 presents a=0xFF, b=0xFF for one accept -> rsp_valid=1 with rsp_id=1, rsp_product=0xFE01, exactly LAT-1 cycles after the accepting edge.
- All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1. Back-to-back responses with ids in the same order. Products match a*b for the operand pairs (3,5)=15, (200,2)=400.
- Backpressure: rsp_ready=0 for 4 cycles with a full pipeline -> rsp_valid/rsp_id/rsp_product stable, req_ready all 0. On release, responses resume in order with none lost or duplicated.
- Mid-operation reset: two operands in flight, then rst_n=0 for 1 cycle -> no rsp_valid for the discarded ops; rr_ptr restarts at 0.
- STATS_EN build: 70000 accepts on requester 2 -> stat_cnt[47:32]=0xFFFF. Then stat_clr=1 together with an accept -> counter reads 0.
